// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like responder: size codes,
// response-queue entry layout and the write byte-lane decoder.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Countdown field wide enough for LATENCY up to 8 (loaded with LATENCY-1).
    localparam int CNT_W = 3;

    typedef struct packed {
        logic             wr;
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } rsp_entry_t;

    function automatic logic [3:0] byte_lanes(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] wen;
        case (size)
            SIZE_BYTE: wen = 4'b0001 << addr_lo;
            SIZE_HALF: wen = 4'b0011 << {addr_lo[1], 1'b0};
            default:   wen = 4'b1111;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/sram_like_rsp_queue.sv
// In-order response queue: DEPTH-entry circular buffer whose entries count
// down to zero; the head answers when its count reaches zero.
module sram_like_rsp_queue
    import sram_like_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     push_wr_i,
    input  logic [31:0]              cap_data_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     pop_o,
    output logic [31:0]              rdata_o
);

    localparam int PW = $clog2(DEPTH);

    rsp_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic              cap_q, cap_d;
    logic [PW-1:0]     cap_idx_q, cap_idx_d;
    logic [31:0]       head_data;

    assign pop_o   = vld_q[head_q] && (ent_q[head_q].cnt == '0);
    assign count_o = count_q;

    // RAM data for a read lands one cycle after accept; a head answering in
    // that same cycle (LATENCY=1) takes it straight from the RAM port.
    assign head_data = (cap_q && (cap_idx_q == head_q)) ? cap_data_i : ent_q[head_q].data;
    assign rdata_o   = (pop_o && !ent_q[head_q].wr) ? head_data : 32'd0;

    always_comb begin
        vld_d     = vld_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        cap_d     = push_i & ~push_wr_i;
        cap_idx_d = tail_q;
        if (pop_o) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (push_i) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + 1'b1;
        end
        case ({push_i, pop_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    // Entry payload needs no reset: the valid bits qualify it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].cnt != '0) ent_q[i].cnt <= ent_q[i].cnt - 1'b1;
        end
        if (cap_q) ent_q[cap_idx_q].data <= cap_data_i;
        if (push_i) ent_q[tail_q] <= '{wr: push_wr_i, data: 32'd0, cnt: CNT_W'(LATENCY - 1)};
    end

endmodule

// File: rtl/sram_like_slave.sv
// Responder end of the sram-like req/addr_ok/data_ok protocol over a single-port
// synchronous RAM. Define SRAM_SLV_STALL_EN for LFSR-driven pseudo-random accept stalls.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int RAM_AW  = 14,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count;
    logic          pop;
    logic          room;
    logic          stall_ok;
    logic          accept;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr[31:RAM_AW+2];

`ifdef SRAM_SLV_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left.
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall_ok = lfsr_q[0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall_ok = 1'b1;
`endif

    // A full queue can still accept in the cycle its head answers.
    assign room    = (count < DEPTH_C) | pop;
    assign addr_ok = req & ~areset & room & stall_ok;
    assign accept  = addr_ok;

    assign ram_en    = accept;
    assign ram_wen   = (accept && wr) ? byte_lanes(size, addr[1:0]) : 4'b0000;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;
    assign data_ok   = pop;

    sram_like_rsp_queue #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_rsp_queue (
        .clk_i      (aclk),
        .rst_i      (areset),
        .push_i     (accept),
        .push_wr_i  (wr),
        .cap_data_i (ram_rdata),
        .count_o    (count),
        .pop_o      (pop),
        .rdata_o    (rdata)
    );

endmodule
